// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported unified memory between the
// instruction-fetch stage (read-only) and the data-memory stage (load/store).
// One transaction is in flight at a time; the owner receives a one-cycle ready
// pulse and the hold outputs freeze the PC / pipeline registers meanwhile.
// All state updates on the falling edge of CLK to match the pipeline registers.
// Optional feature macro: ARB_PERF_CNT_EN adds grant and stall counters.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 2,
  parameter int STARVE_LIMIT = 2
) (
  input  logic              CLK,
  input  logic              Reset_L,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              pc_hold,
  output logic              pipe_hold,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]       perf_if_grants,
  output logic [31:0]       perf_dm_grants,
  output logic [31:0]       perf_stall_cycles,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  // Counter widths sized to hold MEM_LAT and STARVE_LIMIT; at least one bit.
  localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
  localparam int STV_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STV_W-1:0]    starve_q, starve_d;
  logic                owner_dm_q, owner_dm_d;   // 1 = data side owns the port
  logic                we_q, we_d;               // latched direction of transaction
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                if_ready_q, if_ready_d;
  logic                dm_ready_q, dm_ready_d;
  logic                grant_if_s, grant_dm_s;

  assign pc_hold   = if_req & ~if_ready_q;
  assign pipe_hold = dm_req & ~dm_ready_q;

  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Next-state and registered-output logic for the grant/wait/done sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    owner_dm_d  = owner_dm_q;
    we_d        = we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    grant_if_s  = 1'b0;
    grant_dm_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Data wins unless fetch has waited through STARVE_LIMIT data grants.
        if (dm_req && !(if_req && (starve_q >= STV_W'(STARVE_LIMIT)))) begin
          grant_dm_s = 1'b1;
        end else if (if_req) begin
          grant_if_s = 1'b1;
        end else begin
          grant_dm_s = 1'b0;
        end

        if (grant_dm_s) begin
          state_d     = ST_WAIT;
          owner_dm_d  = 1'b1;
          we_d        = dm_we;
          mem_en_d    = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          cnt_d       = dm_we ? CNT_W'(1) : CNT_W'(MEM_LAT);
        end else if (grant_if_s) begin
          state_d     = ST_WAIT;
          owner_dm_d  = 1'b0;
          we_d        = 1'b0;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          cnt_d       = CNT_W'(MEM_LAT);
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_DONE;
          if (owner_dm_q) begin
            dm_ready_d = 1'b1;
            if (!we_q) begin
              dm_rdata_d = mem_rdata;
            end else begin
              dm_rdata_d = dm_rdata_q;
            end
          end else begin
            if_ready_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      // One dead cycle so a requester advancing on ready is not re-granted.
      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Starvation tracking only matters while a fetch is actually waiting.
    if (!if_req) begin
      starve_d = '0;
    end else if (grant_if_s) begin
      starve_d = '0;
    end else if (grant_dm_s && (starve_q < STV_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + STV_W'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(negedge CLK) begin
    if (Reset_L) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      starve_q    <= '0;
      owner_dm_q  <= 1'b0;
      we_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      owner_dm_q  <= owner_dm_d;
      we_q        <= we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_q, perf_if_d;
  logic [31:0] perf_dm_q, perf_dm_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  assign perf_if_grants    = perf_if_q;
  assign perf_dm_grants    = perf_dm_q;
  assign perf_stall_cycles = perf_stall_q;

  // Wrapping event counters for grants and held-pipeline edges.
  always_comb begin
    perf_if_d    = perf_if_q;
    perf_dm_d    = perf_dm_q;
    perf_stall_d = perf_stall_q;
    if (grant_if_s) begin
      perf_if_d = perf_if_q + 32'd1;
    end else begin
      perf_if_d = perf_if_q;
    end
    if (grant_dm_s) begin
      perf_dm_d = perf_dm_q + 32'd1;
    end else begin
      perf_dm_d = perf_dm_q;
    end
    if (pc_hold | pipe_hold) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end else begin
      perf_stall_d = perf_stall_q;
    end
  end

  // Performance counter registers, cleared by reset.
  always_ff @(negedge CLK) begin
    if (Reset_L) begin
      perf_if_q    <= 32'd0;
      perf_dm_q    <= 32'd0;
      perf_stall_q <= 32'd0;
    end else begin
      perf_if_q    <= perf_if_d;
      perf_dm_q    <= perf_dm_d;
      perf_stall_q <= perf_stall_d;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (default build, MEM_LAT=2,
// STARVE_LIMIT=2). The DUT updates on the falling edge; the bench drives and
// samples 1 time unit after each falling edge.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        Reset_L;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        pc_hold;
  logic        pipe_hold;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_LIMIT(2)
  ) dut (
    .CLK(CLK), .Reset_L(Reset_L),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .pc_hold(pc_hold), .pipe_hold(pipe_hold),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int          grants;
    logic [5:0]  order;
    logic [5:0]  exp_order;

    Reset_L = 1'b1; if_req = 1'b0; if_addr = 32'h0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = 32'h0; dm_wdata = 32'h0; mem_rdata = 32'h0;

    // Reset held two edges, then released with no requests.
    tick(); tick();
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_dm_rdata", dm_rdata, 32'h0);
    check("rst_readies", {30'd0, if_ready, dm_ready}, 32'd0);
    Reset_L = 1'b0;
    tick();
    check("idle1_mem_en", {31'd0, mem_en}, 32'd0);
    tick();
    check("idle2_mem_en", {31'd0, mem_en}, 32'd0);
    check("idle2_holds", {30'd0, pc_hold, pipe_hold}, 32'd0);

    // Single fetch read.
    if_req = 1'b1; if_addr = 32'h0000_0040; mem_rdata = 32'h8C22_0004;
    #1;
    check("f_pc_hold_pre", {31'd0, pc_hold}, 32'd1);
    tick();
    check("f_e0_mem_en", {31'd0, mem_en}, 32'd1);
    check("f_e0_mem_addr", mem_addr, 32'h40);
    check("f_e0_mem_we", {31'd0, mem_we}, 32'd0);
    check("f_e0_if_ready", {31'd0, if_ready}, 32'd0);
    tick();
    check("f_e1_mem_en", {31'd0, mem_en}, 32'd0);
    check("f_e1_if_ready", {31'd0, if_ready}, 32'd0);
    check("f_e1_pc_hold", {31'd0, pc_hold}, 32'd1);
    tick();
    check("f_e2_if_ready", {31'd0, if_ready}, 32'd1);
    check("f_e2_if_rdata", if_rdata, 32'h8C22_0004);
    check("f_e2_pc_hold", {31'd0, pc_hold}, 32'd0);
    check("f_e2_dm_ready", {31'd0, dm_ready}, 32'd0);
    if_req = 1'b0;
    tick();
    check("f_e3_if_ready", {31'd0, if_ready}, 32'd0);
    check("f_e3_mem_en", {31'd0, mem_en}, 32'd0);

    // Single store.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h10; dm_wdata = 32'hDEAD_BEEF;
    #1;
    check("s_pipe_hold_pre", {31'd0, pipe_hold}, 32'd1);
    tick();
    check("s_e0_mem_en", {31'd0, mem_en}, 32'd1);
    check("s_e0_mem_we", {31'd0, mem_we}, 32'd1);
    check("s_e0_mem_addr", mem_addr, 32'h10);
    check("s_e0_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    check("s_e1_dm_ready", {31'd0, dm_ready}, 32'd1);
    check("s_e1_if_ready", {31'd0, if_ready}, 32'd0);
    check("s_e1_pipe_hold", {31'd0, pipe_hold}, 32'd0);
    check("s_e1_dm_rdata", dm_rdata, 32'h0);
    check("s_e1_mem_en", {31'd0, mem_en}, 32'd0);
    dm_req = 1'b0; dm_we = 1'b0;
    tick();
    check("s_e2_dm_ready", {31'd0, dm_ready}, 32'd0);

    // Simultaneous requests: load granted first, fetch after DONE.
    if_req = 1'b1; if_addr = 32'h44; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
    mem_rdata = 32'h1234_5678;
    tick();
    check("b_e0_mem_en", {31'd0, mem_en}, 32'd1);
    check("b_e0_mem_addr", mem_addr, 32'h20);
    check("b_e0_mem_we", {31'd0, mem_we}, 32'd0);
    tick();
    tick();
    check("b_e2_dm_ready", {31'd0, dm_ready}, 32'd1);
    check("b_e2_dm_rdata", dm_rdata, 32'h1234_5678);
    check("b_e2_if_ready", {31'd0, if_ready}, 32'd0);
    check("b_e2_pc_hold", {31'd0, pc_hold}, 32'd1);
    check("b_e2_if_rdata_hold", if_rdata, 32'h8C22_0004);
    dm_req = 1'b0;
    tick();
    check("b_e3_mem_en", {31'd0, mem_en}, 32'd0);
    check("b_e3_dm_ready", {31'd0, dm_ready}, 32'd0);
    mem_rdata = 32'hAAAA_5555;
    tick();
    check("b_e4_mem_en", {31'd0, mem_en}, 32'd1);
    check("b_e4_mem_addr", mem_addr, 32'h44);
    tick();
    tick();
    check("b_e6_if_ready", {31'd0, if_ready}, 32'd1);
    check("b_e6_if_rdata", if_rdata, 32'hAAAA_5555);
    check("b_e6_dm_rdata_hold", dm_rdata, 32'h1234_5678);
    if_req = 1'b0;
    tick();

    // Starvation: both held continuously, expected grants dm,dm,if,dm,dm,if.
    if_req = 1'b1; if_addr = 32'h48; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h30;
    grants = 0; order = 6'b0;
    exp_order = 6'b011011;  // bit i = 1 when grant i goes to the data side
    for (int c = 0; c < 40 && grants < 6; c++) begin
      tick();
      if (mem_en) begin
        order[grants] = (mem_addr == 32'h30);
        grants++;
      end
    end
    check("stv_grant_count", grants, 32'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("stv_grant%0d", i), {31'd0, order[i]}, {31'd0, exp_order[i]});
    end
    // Requests dropped early: the in-flight fetch still completes.
    if_req = 1'b0; dm_req = 1'b0;
    tick();
    tick();
    check("stv_last_if_ready", {31'd0, if_ready}, 32'd1);
    check("stv_last_dm_ready", {31'd0, dm_ready}, 32'd0);
    tick();

    // Reset during WAIT aborts the read.
    if_req = 1'b1; if_addr = 32'h50; mem_rdata = 32'h0BAD_F00D;
    tick();
    check("r_e0_mem_en", {31'd0, mem_en}, 32'd1);
    Reset_L = 1'b1;
    tick();
    check("r_rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("r_rst_if_ready", {31'd0, if_ready}, 32'd0);
    check("r_rst_mem_addr", mem_addr, 32'h0);
    check("r_rst_if_rdata", if_rdata, 32'h0);
    Reset_L = 1'b0;
    tick();
    check("r_regrant_mem_en", {31'd0, mem_en}, 32'd1);
    check("r_regrant_if_ready", {31'd0, if_ready}, 32'd0);
    check("r_regrant_mem_addr", mem_addr, 32'h50);
    tick();
    tick();
    check("r_if_ready", {31'd0, if_ready}, 32'd1);
    check("r_if_rdata", if_rdata, 32'h0BAD_F00D);
    if_req = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch stage (read-only) and the data-memory stage (load/store) of the pipelined MIPS core.
- Issues one memory transaction at a time, returns the response to the owning requester, and drives hold signals so the PC and pipeline registers freeze while a request is outstanding.
- Sits between the IF/MEM stage logic and the memory macro.

Parameters:
ADDR_W, 32, address width of requesters and memory
DATA_W, 32, data width
MEM_LAT, 2, read latency: edges from mem_en capture to mem_rdata sample (>=1)
STARVE_LIMIT, 2, consecutive data-side grants after which a waiting fetch wins

Ports:
CLK  in  1  clock; all state updates on falling edge, matching pipeline registers
Reset_L  in  1  synchronous, active-high reset (high = reset, despite the name)
if_req  in  1  fetch request; held until if_ready
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched instruction, valid while if_ready=1
if_ready  out  1  one-cycle completion pulse for fetch
dm_req  in  1  data request; held until dm_ready
dm_we  in  1  1=store, 0=load
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_rdata  out  DATA_W  load data, valid while dm_ready=1
dm_ready  out  1  one-cycle completion pulse for data
pc_hold  out  1  if_req & ~if_ready (combinational)
pipe_hold  out  1  dm_req & ~dm_ready (combinational)
mem_en  out  1  one-cycle transaction strobe
mem_we  out  1  write enable, qualified by mem_en
mem_addr  out  ADDR_W  transaction address
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  read data from memory

Behaviour:
- Reset (Reset_L=1 at an edge): state IDLE; mem_en, mem_we, if_ready, dm_ready=0; mem_addr, mem_wdata, if_rdata, dm_rdata=0; starve count=0; owner cleared. Reset mid-transaction aborts it, produces no ready pulse, and ignores pending mem_rdata.
- FSM states: IDLE, WAIT, DONE. All outputs except the holds are registered.
- IDLE: at edge e0 with any request present, grant one, latch owner, address, we and wdata, drive mem_en=1 for the following cycle only, load counter = MEM_LAT for reads or 1 for writes, then go to WAIT. No request: stay in IDLE.
- Grant rule: dm_req wins over if_req. Exception: if both are requesting and starve count >= STARVE_LIMIT, if_req wins.
- Starve count: +1 on each data grant while if_req=1 (saturating at STARVE_LIMIT); reset to 0 on a fetch grant or when if_req=0.
- WAIT: decrement counter each edge. At the edge where counter=1:
  - read: capture mem_rdata into the owner's rdata.
  - assert the owner's ready for exactly one cycle and go to DONE.
- Read ready rises after edge e0+MEM_LAT. Write ready rises after edge e0+1.
- DONE: next edge returns to IDLE with ready=0 and no grant. This keeps a stale request from being re-granted in the same cycle the requester advances. Throughput: one read per MEM_LAT+2 cycles.
- Non-owner rdata holds its last value. Ready pulses are mutually exclusive.
- Protocol: a requester must not drop req before ready. If it does, the transaction still completes and ready still pulses.
- Simultaneous if_req and dm_req in IDLE: only one is granted; the other's hold stays high until its own ready.

Optional Feature:
ARB_PERF_CNT_EN
- Defined: adds outputs perf_if_grants, perf_dm_grants, perf_stall_cycles (32 bits each, wrapping). Grant counters increment at each grant. Stall counter increments on each edge where pc_hold|pipe_hold=1. All counters clear on reset.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset held 2 edges, then released with no requests -> all outputs 0, state IDLE, mem_en never asserted.
- if_req=1, if_addr=0x00000040, MEM_LAT=2, memory returns 0x8C220004 -> mem_en=1 one cycle with mem_addr=0x40, mem_we=0; if_ready pulses after the second edge with if_rdata=0x8C220004; pc_hold high until then.
- dm_req store, dm_addr=0x10, dm_wdata=0xDEADBEEF -> mem_en=1, mem_we=1, mem_wdata=0xDEADBEEF; dm_ready pulses after one edge; if_ready stays 0.
- if_req and dm_req asserted together, dm a load -> data granted first and dm_ready pulses; fetch granted on the first IDLE edge after the DONE cycle.
- if_req held with dm_req held continuously, STARVE_LIMIT=2 -> grant order dm, dm, if, dm, dm, if.
- Reset_L=1 during WAIT of a read -> no ready pulse, mem_en=0, next request served normally from IDLE.
